// File: rtl/tristate_mem_bank.sv
// tristate_mem_bank: one bank of a multi-bank memory sharing a tristate data bus.
// Upper address bits select the bank, lower bits index the word array. Reads are
// registered with a configurable latency, drive the bus for exactly one cycle and
// are followed by a one-cycle turnaround. Bus contention while driving is sticky.
module tristate_mem_bank #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned BANK_ID  = 0,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  logic [DATA_W-1:0] data_bus,
  input  logic [ADDR_W-1:0] addr,
  input  logic              req,
  input  logic              we,
  output logic              ack,
  output logic              busy,
  output logic              drive_en,
  output logic              err,
  output logic              contention
);

  localparam int unsigned WORD_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BANK_W  = ADDR_W - WORD_AW;
  localparam int unsigned CNT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RWAIT = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_W-1:0]     rdata;
  logic                  ack_wr;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic [BANK_W-1:0]     bank_field;
  logic [WORD_AW-1:0]    idx;
  logic                  bank_hit;
  logic                  sel;
  logic                  in_range;
  logic                  wr_accept;
  logic                  rd_accept;

  assign bank_field = addr[ADDR_W-1:WORD_AW];
  assign idx        = addr[WORD_AW-1:0];
  // Compare at 64 bits so a BANK_ID wider than the bank field can never match.
  assign bank_hit   = (64'(bank_field) == 64'(BANK_ID));
  assign sel        = req && bank_hit;
  assign in_range   = (32'(idx) < DEPTH);
  assign wr_accept  = (state_q == IDLE) && sel && we;
  assign rd_accept  = (state_q == IDLE) && sel && !we;

  assign busy     = (state_q != IDLE);
  assign drive_en = (state_q == DRIVE);
  assign ack      = ack_wr | drive_en;
  assign data_bus = drive_en ? rdata : {DATA_W{1'bz}};

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: read accept, latency countdown, one drive cycle, turnaround.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rd_accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (CNT_LOAD == '0) ? DRIVE : RWAIT;
        end
      end
      RWAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DRIVE;
      end
      DRIVE:   state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-data latch, write ack, error pulse and sticky contention flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata      <= '0;
      ack_wr     <= 1'b0;
      err        <= 1'b0;
      contention <= 1'b0;
    end else begin
      ack_wr <= wr_accept;
      err    <= (wr_accept || rd_accept) && !in_range;
      if (rd_accept) rdata <= in_range ? mem[idx] : '0;
      if ((state_q == DRIVE) && (data_bus !== rdata)) contention <= 1'b1;
    end
  end

  // Word array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept && in_range) mem[idx] <= data_bus;
  end

endmodule
